// File: rtl/display_pkg.sv
// Shared types and register map for the display frame-update host.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_VBLANK = 2'd1,
    WRITE       = 2'd2,
    DONE        = 2'd3
  } state_t;

  localparam int NUM_REGS = 7;

  // Peripheral register addresses; address 7 is the peripheral's read-only flags.
  localparam logic [2:0] ADDR_PLAYER_Y  = 3'd0;
  localparam logic [2:0] ADDR_X_SHIFT   = 3'd1;
  localparam logic [2:0] ADDR_BG_R      = 3'd2;
  localparam logic [2:0] ADDR_BG_G      = 3'd3;
  localparam logic [2:0] ADDR_BG_B      = 3'd4;
  localparam logic [2:0] ADDR_MAP_BLOCK = 3'd5;
  localparam logic [2:0] ADDR_FLAGS     = 3'd6;

  function automatic logic [15:0] zext8(input logic [7:0] v);
    return {8'h00, v};
  endfunction

endpackage

// File: rtl/dirty_prio_enc.sv
// Lowest-set-bit selector over the dirty mask; purely combinational.
module dirty_prio_enc
  import display_pkg::*;
(
  input  logic [NUM_REGS-1:0] i_mask,
  output logic [2:0]          o_idx,
  output logic                o_any
);

  logic [2:0] w_idx;

  // Scan high to low so the lowest set bit is the last one to win.
  always_comb begin
    w_idx = 3'd0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (i_mask[i]) w_idx = 3'(i);
    end
  end

  assign o_idx = w_idx;
  assign o_any = |i_mask;

endmodule

// File: rtl/frame_update_master.sv
// Accepts a frame update, waits for the next vblank, then writes only the changed
// peripheral registers over Avalon-MM, lowest address first, with no gaps between writes.
module frame_update_master
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_player_y,
  input  logic [15:0] upd_x_shift,
  input  logic [7:0]  upd_bg_r,
  input  logic [7:0]  upd_bg_g,
  input  logic [7:0]  upd_bg_b,
  input  logic [7:0]  upd_map_block,
  input  logic [7:0]  upd_flags,
  input  logic        vga_vs,
  output logic [2:0]  avm_address,
  output logic [15:0] avm_writedata,
  output logic        avm_write,
  output logic        avm_chipselect,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic [15:0] upd_count
);

  state_t                          r_state;
  state_t                          w_next;
  logic                            r_vs_q;
  logic [NUM_REGS-1:0][15:0]       r_fld;
  logic [NUM_REGS-1:0][15:0]       r_shadow;
  logic                            r_shadow_vld;
  logic [NUM_REGS-1:0]             r_dirty;
  logic [15:0]                     r_count;

  logic [NUM_REGS-1:0][15:0]       w_in;
  logic [NUM_REGS-1:0]             w_new_dirty;
  logic [NUM_REGS-1:0]             w_dirty_clr;
  logic [2:0]                      w_idx;
  logic                            w_any;
  logic                            w_accept;
  logic                            w_vblank_edge;
  logic                            w_wr_done;

  always_comb begin
    w_in                 = '0;
    w_in[ADDR_PLAYER_Y]  = upd_player_y;
    w_in[ADDR_X_SHIFT]   = upd_x_shift;
    w_in[ADDR_BG_R]      = zext8(upd_bg_r);
    w_in[ADDR_BG_G]      = zext8(upd_bg_g);
    w_in[ADDR_BG_B]      = zext8(upd_bg_b);
    w_in[ADDR_MAP_BLOCK] = zext8(upd_map_block);
    w_in[ADDR_FLAGS]     = zext8(upd_flags);
  end

  // An invalid shadow (after reset) marks every register dirty.
  always_comb begin
    w_new_dirty = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_new_dirty[i] = ~r_shadow_vld | (w_in[i] != r_shadow[i]);
    end
  end

  dirty_prio_enc u_prio (
    .i_mask (r_dirty),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_comb begin
    w_dirty_clr = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_dirty_clr[i] = r_dirty[i] & (w_idx != 3'(i));
    end
  end

  assign w_accept      = upd_valid & (r_state == IDLE);
  assign w_vblank_edge = r_vs_q & ~vga_vs;
  assign w_wr_done     = (r_state == WRITE) & w_any & ~avm_waitrequest;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (upd_valid) w_next = (|w_new_dirty) ? WAIT_VBLANK : DONE;
      end
      WAIT_VBLANK: begin
        if (w_vblank_edge) w_next = WRITE;
      end
      WRITE: begin
        if (!w_any)                                   w_next = DONE;
        else if (w_wr_done && (w_dirty_clr == '0))    w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vs_q       <= 1'b1;
      r_fld        <= '0;
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
      r_dirty      <= '0;
      r_count      <= 16'd0;
    end else begin
      r_vs_q <= vga_vs;
      if (w_accept) begin
        r_fld   <= w_in;
        r_dirty <= w_new_dirty;
      end else if (w_wr_done) begin
        r_dirty <= w_dirty_clr;
      end
      if (r_state == DONE) begin
        r_shadow     <= r_fld;
        r_shadow_vld <= 1'b1;
        r_count      <= r_count + 16'd1;
      end
    end
  end

  // Bus outputs decode straight from registered state, so they hold steady under waitrequest.
  assign avm_write      = (r_state == WRITE) & w_any;
  assign avm_chipselect = (r_state == WRITE) & w_any;
  assign avm_address    = (r_state == WRITE) ? w_idx : 3'd0;
  assign avm_writedata  = (r_state == WRITE) ? r_fld[w_idx] : 16'd0;

  assign upd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign upd_count = r_count;

endmodule

// File: tb/tb_frame_update_master.sv
// Directed bench for frame_update_master with hand-computed expectations.
module tb_frame_update_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_player_y, upd_x_shift;
  logic [7:0]  upd_bg_r, upd_bg_g, upd_bg_b, upd_map_block, upd_flags;
  logic        vga_vs;
  logic [2:0]  avm_address;
  logic [15:0] avm_writedata;
  logic        avm_write, avm_chipselect, avm_waitrequest;
  logic        busy;
  logic [15:0] upd_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_a [7];
  logic [15:0] exp_b [7];

  frame_update_master dut (
    .clk             (clk),
    .reset           (reset),
    .upd_valid       (upd_valid),
    .upd_ready       (upd_ready),
    .upd_player_y    (upd_player_y),
    .upd_x_shift     (upd_x_shift),
    .upd_bg_r        (upd_bg_r),
    .upd_bg_g        (upd_bg_g),
    .upd_bg_b        (upd_bg_b),
    .upd_map_block   (upd_map_block),
    .upd_flags       (upd_flags),
    .vga_vs          (vga_vs),
    .avm_address     (avm_address),
    .avm_writedata   (avm_writedata),
    .avm_write       (avm_write),
    .avm_chipselect  (avm_chipselect),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .upd_count       (upd_count)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [15:0] py, input logic [15:0] xs, input logic [7:0] r,
                            input logic [7:0] g, input logic [7:0] b, input logic [7:0] mb,
                            input logic [7:0] fl);
    upd_player_y = py; upd_x_shift = xs; upd_bg_r = r; upd_bg_g = g;
    upd_bg_b = b; upd_map_block = mb; upd_flags = fl;
  endtask

  // Offer the update for one edge; the block is expected to take it immediately.
  task automatic accept();
    upd_valid = 1'b1;
    chk("ready_before_accept", upd_ready, 1);
    tick();
    upd_valid = 1'b0;
  endtask

  // Falling vga_vs for one edge; vga_vs must have been high for the previous edge.
  task automatic vblank();
    vga_vs = 1'b0;
    tick();
    vga_vs = 1'b1;
  endtask

  task automatic chk_write(input string tag, input logic [2:0] a, input logic [15:0] d);
    chk({tag, "_write"}, avm_write, 1);
    chk({tag, "_cs"},    avm_chipselect, 1);
    chk({tag, "_addr"},  avm_address, a);
    chk({tag, "_data"},  avm_writedata, d);
  endtask

  initial begin
    exp_a = '{16'h0100, 16'h0002, 16'h0010, 16'h0020, 16'h0030, 16'h0005, 16'h0001};
    exp_b = '{16'h1111, 16'h2222, 16'h0033, 16'h0020, 16'h0041, 16'h0005, 16'h0001};
    reset = 1'b1; upd_valid = 1'b0; vga_vs = 1'b1; avm_waitrequest = 1'b0;
    set_fields(16'h0100, 16'h0002, 8'h10, 8'h20, 8'h30, 8'h05, 8'h01);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", upd_ready, 1);
    chk("rst_write", avm_write, 0);
    chk("rst_cs", avm_chipselect, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_data", avm_writedata, 0);
    chk("rst_count", upd_count, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // First update: shadow invalid, all seven registers written after the vblank edge.
    accept();
    chk("t1_busy", busy, 1);
    chk("t1_ready", upd_ready, 0);
    chk("t1_wait_nowrite", avm_write, 0);
    tick();
    chk("t1_still_waiting", avm_write, 0);
    vblank();
    for (int i = 0; i < 7; i++) begin
      chk_write($sformatf("t1_w%0d", i), 3'(i), exp_a[i]);
      tick();
    end
    chk("t1_done_nowrite", avm_write, 0);
    chk("t1_done_busy", busy, 1);
    chk("t1_done_count", upd_count, 0);
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_count", upd_count, 1);

    // Identical update: no bus activity, DONE one cycle after accept.
    accept();
    chk("t2_done_busy", busy, 1);
    chk("t2_done_ready", upd_ready, 0);
    chk("t2_nowrite", avm_write, 0);
    tick();
    chk("t2_idle", busy, 0);
    chk("t2_count", upd_count, 2);

    // Only x_shift and bg_b change: two back-to-back writes.
    set_fields(16'h0100, 16'h0003, 8'h10, 8'h20, 8'h40, 8'h05, 8'h01);
    accept();
    vblank();
    chk_write("t3_a1", 3'd1, 16'h0003);
    tick();
    chk_write("t3_a4", 3'd4, 16'h0040);
    tick();
    chk("t3_done_nowrite", avm_write, 0);
    tick();
    chk("t3_count", upd_count, 3);

    // Waitrequest high for 3 cycles on the address-1 write.
    set_fields(16'h0100, 16'h0007, 8'h10, 8'h20, 8'h41, 8'h05, 8'h01);
    accept();
    avm_waitrequest = 1'b1;
    vblank();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) avm_waitrequest = 1'b0;
      chk_write($sformatf("t4_hold%0d", k), 3'd1, 16'h0007);
      tick();
    end
    chk_write("t4_a4", 3'd4, 16'h0041);
    tick();
    chk("t4_done_nowrite", avm_write, 0);
    tick();
    chk("t4_count", upd_count, 4);

    // Vblank edge in the accept cycle is ignored.
    set_fields(16'h0200, 16'h0007, 8'h10, 8'h20, 8'h41, 8'h05, 8'h01);
    vga_vs = 1'b0;
    accept();
    vga_vs = 1'b1;
    chk("t5_no_early_write0", avm_write, 0);
    tick();
    chk("t5_no_early_write1", avm_write, 0);
    tick();
    chk("t5_no_early_write2", avm_write, 0);
    chk("t5_busy", busy, 1);
    vblank();
    chk_write("t5_a0", 3'd0, 16'h0200);
    tick();
    chk("t5_done_nowrite", avm_write, 0);
    tick();
    chk("t5_count", upd_count, 5);

    // Reset during the third write, then a full rewrite of all seven registers.
    set_fields(16'h1111, 16'h2222, 8'h33, 8'h20, 8'h41, 8'h05, 8'h01);
    accept();
    vblank();
    chk_write("t6_w0", 3'd0, 16'h1111);
    tick();
    chk_write("t6_w1", 3'd1, 16'h2222);
    tick();
    chk_write("t6_w2", 3'd2, 16'h0033);
    reset = 1'b1;
    #2;
    chk("t6_rst_write", avm_write, 0);
    chk("t6_rst_cs", avm_chipselect, 0);
    chk("t6_rst_idle", busy, 0);
    chk("t6_rst_ready", upd_ready, 1);
    chk("t6_rst_count", upd_count, 0);
    #3;
    reset = 1'b0;
    tick();
    accept();
    vblank();
    for (int i = 0; i < 7; i++) begin
      chk_write($sformatf("t6_re_w%0d", i), 3'(i), exp_b[i]);
      tick();
    end
    chk("t6_done_nowrite", avm_write, 0);
    tick();
    chk("t6_idle", busy, 0);
    chk("t6_count", upd_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_update_master.md
FRAME_UPDATE_MASTER -- requirements
Module: frame_update_master

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock (50 MHz system clock).
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port upd_valid, input, 1 bit: a frame update is offered.
REQ-004 SHALL have port upd_ready, output, 1 bit: the block accepts the update this cycle.
REQ-005 SHALL have ports upd_player_y and upd_x_shift, input, 16 bits each: values for peripheral registers 0 and 1.
REQ-006 SHALL have ports upd_bg_r, upd_bg_g, upd_bg_b, upd_map_block and upd_flags, input, 8 bits each: values for registers 2 to 6.
REQ-007 SHALL have port vga_vs, input, 1 bit: active-low vertical sync from the display peripheral.
REQ-008 SHALL have ports avm_address (output, 3 bits), avm_writedata (output, 16 bits), avm_write (output, 1 bit), avm_chipselect (output, 1 bit) and avm_waitrequest (input, 1 bit): Avalon-MM write host to the display peripheral.
REQ-009 SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-010 SHALL have port upd_count, output, 16 bits: number of completed updates, wrapping modulo 2^16.

Function
REQ-011 SHALL implement the states IDLE, WAIT_VBLANK, WRITE and DONE.
REQ-012 SHALL drive upd_ready = 1 only in IDLE; on upd_valid & upd_ready it latches all seven fields and computes a 7-bit dirty mask.
REQ-013 SHALL set dirty bit i when latched field i differs from shadow register i, or when the shadow is invalid.
REQ-014 SHALL go to DONE on accept when the dirty mask is zero, with no bus activity; otherwise it goes to WAIT_VBLANK.
REQ-015 SHALL register vga_vs into vs_q each cycle; vblank_edge = vs_q & ~vga_vs.
REQ-016 SHALL move WAIT_VBLANK -> WRITE on vblank_edge; an edge in the accept cycle is ignored, and the block waits for the next frame.
REQ-017 SHALL in WRITE select the lowest set dirty bit as the index, drive avm_address = index, avm_write = avm_chipselect = 1, and avm_writedata = the field (8-bit fields zero-extended).
REQ-018 SHALL hold address, data and write stable while avm_waitrequest = 1, and complete the write in the first cycle in which avm_waitrequest = 0.
REQ-019 SHALL on write completion clear the dirty bit, so the next dirty index follows in the next cycle with no idle gap; clean indices are skipped in zero cycles.
REQ-020 SHALL move to DONE in the cycle after the last dirty write completes.
REQ-021 SHALL never drive address 7 (output flags register).
REQ-022 SHALL spend exactly one cycle in DONE: copy the latched fields into the shadow, set shadow valid, increment upd_count, then go to IDLE.
REQ-023 SHALL drive avm_write = avm_chipselect = 0 in every state other than WRITE.
REQ-024 SHALL make the latency from accept to the first write equal to the cycles until the next vblank edge, plus 1.

Reset
REQ-025 SHALL on reset immediately force the state to IDLE, avm_write = avm_chipselect = 0, avm_address = 0, avm_writedata = 0, upd_count = 0, vs_q = 1 and shadow valid = 0, with shadow values at 0.
REQ-026 SHALL abandon any write in progress on reset mid-operation and leave upd_count unchanged by it; the next update writes all seven registers.

Structure
REQ-027 SHALL place the state enum, register-address constants (0 to 6) and NUM_REGS = 7 in the shared package display_pkg.
REQ-028 SHALL implement the lowest-set-bit selector as sub-module dirty_prio_enc (7-bit mask in; 3-bit index and any-set flag out).

Verification
REQ-029 SHALL cover first update after reset: fields 0x0100, 0x0002, 0x10, 0x20, 0x30, 0x05 and 0x01, with waitrequest = 0 -> after the vblank edge, 7 consecutive writes to addresses 0..6 with matching data, then upd_count = 1.
REQ-030 SHALL cover a repeated identical update -> no avm_write asserted, upd_count = 2, and DONE reached one cycle after accept.
REQ-031 SHALL cover a change of only upd_x_shift to 0x0003 and upd_bg_b to 0x40 -> exactly two back-to-back writes, address 1 with data 0x0003 then address 4 with data 0x0040.
REQ-032 SHALL cover waitrequest held high for 3 cycles on the address-1 write -> address and data held 4 cycles with no write skipped.
REQ-033 SHALL cover a vblank edge coinciding with the accept cycle -> no write until the following edge.
REQ-034 SHALL cover reset asserted during the third write -> avm_write low in the same cycle, IDLE, upd_count = 0, and the next update writes all 7 registers.
